serial_subtractor_nbit: RTL and testbench
=========================================

Name: serial_subtractor_nbit

Overview:
- Multi-cycle, bit-serial N-bit subtractor. Computes a - b - borrow_in one bit per clock, LSB first, using a single registered borrow.
- Complements the combinational n-bit adder used in the arithmetic datapath. Serves as the area-lean inverse operation for lab datapaths.
- Uses a start/busy/done handshake. The result is held stable until the next accepted operation.

Parameters:
NUM_BITS, 8, operand and difference width (>= 2)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled on rising clk
a  input  NUM_BITS  minuend; sampled only on the edge that accepts start
b  input  NUM_BITS  subtrahend; sampled only on the edge that accepts start
borrow_in  input  1  initial borrow; sampled with a/b
busy  output  1  high while the bit-serial computation is in progress
done  output  1  one-cycle pulse: diff/underflow updated this cycle
diff  output  NUM_BITS  registered result (a - b - borrow_in) mod 2^NUM_BITS
underflow  output  1  final borrow out (1 when a < b + borrow_in, unsigned)

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE.
  - busy, done, diff, underflow, bit counter, operand shift regs and borrow reg all 0.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - On a rising edge with start=1: load a_sr=a, b_sr=b, br=borrow_in, cnt=0, then go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT (busy=1, combinational from state):
  - Each edge computes d = a_sr[0] ^ b_sr[0] ^ br and br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - a_sr and b_sr shift right by 1. d shifts into the MSB of the internal result shift reg r_sr. cnt increments.
  - On the edge where cnt == NUM_BITS-1:
    - copy the final r_sr (including that edge's d) into diff;
    - copy br_next into underflow;
    - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 on this edge is accepted exactly as in IDLE and goes straight to SHIFT.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k → busy high for edges k+1 .. k+NUM_BITS. diff/underflow change at edge k+NUM_BITS. done is high in the cycle following edge k+NUM_BITS.
- diff and underflow change only on the transition SHIFT→DONE. They hold their previous result throughout a new computation.
- start during SHIFT is ignored. Operands are not re-sampled and no error is flagged.
- a/b/borrow_in changing during SHIFT has no effect.
- Reset asserted mid-operation aborts immediately: outputs are forced to reset values and done never pulses for the aborted operation.
- Counter width is $clog2(NUM_BITS). The counter never wraps past NUM_BITS-1.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - adds output port signed_ovf (1 bit, reset 0), registered alongside diff;
  - value = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands (two's-complement overflow);
  - updates and holds under the same rules as diff.
- Undefined: the port and its logic are absent, and the module has exactly the port list above.

Test Plan:
- NUM_BITS=8; a=0x50, b=0x20, borrow_in=0, start 1 cycle → busy 8 cycles; done pulses 9 cycles after the start edge; diff=0x30, underflow=0.
- a=0x00, b=0x01, borrow_in=0 → diff=0xFF, underflow=1. Then a=0x10, b=0x10, borrow_in=1 → diff=0xFF, underflow=1. Then a=0xFF, b=0x00, borrow_in=1 → diff=0xFE, underflow=0.
- Start op a=0x05, b=0x03. At cycle 3 of SHIFT, assert start with a=0xAA, b=0x11 → second start ignored; result diff=0x02, underflow=0; exactly one done pulse.
- Back-to-back: assert start during the DONE cycle with a=0x09, b=0x0A → immediate SHIFT; diff holds the prior 0x02 until the new done; then diff=0xFF, underflow=1.
- Reset mid-operation: pull n_rst low at SHIFT cycle 4 → busy/done/diff/underflow = 0 asynchronously; no done pulse. Release reset; a new op a=0x7F, b=0x7F → diff=0x00, underflow=0.
- With SERIAL_SUB_SIGNED_OVF_EN: a=0x80, b=0x01 → diff=0x7F, signed_ovf=1, underflow=0. a=0x10, b=0x20 → diff=0xF0, signed_ovf=0, underflow=1.

Source files
------------

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor_nbit #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic                signed_ovf
`endif
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(NUM_BITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] a_sr_q, b_sr_q, r_sr_q;
  logic                br_q;
  logic [CntW-1:0]     cnt_q;

  logic                accept, shift, last;
  logic                bit_d, br_next;
  logic [NUM_BITS-1:0] r_next;

  assign shift  = (state_q == StShift);
  assign last   = shift && (cnt_q == CntMax);
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // Full-subtractor cell on the current LSBs.
  assign bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign r_next  = {bit_d, r_sr_q[NUM_BITS-1:1]};

  assign busy = shift;
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntMax) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      r_sr_q    <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      diff      <= '0;
      underflow <= 1'b0;
    end else if (accept) begin
      a_sr_q <= a;
      b_sr_q <= b;
      br_q   <= borrow_in;
      cnt_q  <= '0;
    end else if (shift) begin
      a_sr_q <= a_sr_q >> 1;
      b_sr_q <= b_sr_q >> 1;
      br_q   <= br_next;
      r_sr_q <= r_next;
      if (last) begin
        diff      <= r_next;
        underflow <= br_next;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // On the final shift the LSBs of the operand registers are the original MSBs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      signed_ovf <= 1'b0;
    end else if (last) begin
      signed_ovf <= (a_sr_q[0] != b_sr_q[0]) && (bit_d != a_sr_q[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed self-checking bench for serial_subtractor_nbit (NUM_BITS = 8).
// Define SERIAL_SUB_SIGNED_OVF_EN to also exercise the signed overflow output.
module tb_serial_subtractor_nbit;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy, done, underflow;
  logic [N-1:0] diff;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         signed_ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;

  serial_subtractor_nbit #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .underflow (underflow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .signed_ovf(signed_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus/measurement only: issue one op and report what was observed.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bin,
                        output logic [N-1:0] d, output logic uf, output int lat,
                        output int busy_cyc, output logic done_after);
    @(negedge clk);
    a = av; b = bv; borrow_in = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    d = diff;
    uf = underflow;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    #10;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", diff); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b want 0", underflow); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] d; logic uf, da; int lat, bc;
    run_op(8'h50, 8'h20, 1'b0, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'h30) begin n_fail++; $display("FAIL basic_diff got %h want 30", d); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL basic_uf got %b want 0", uf); end
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
    n_checks++; if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", da); end
  endtask

  task automatic test_underflow();
    logic [N-1:0] d; logic uf, da; int lat, bc;
    run_op(8'h00, 8'h01, 1'b0, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL uf1_diff got %h want ff", d); end
    n_checks++; if (uf !== 1'b1) begin n_fail++; $display("FAIL uf1_uf got %b want 1", uf); end
    run_op(8'h10, 8'h10, 1'b1, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL uf2_diff got %h want ff", d); end
    n_checks++; if (uf !== 1'b1) begin n_fail++; $display("FAIL uf2_uf got %b want 1", uf); end
    run_op(8'hFF, 8'h00, 1'b1, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'hFE) begin n_fail++; $display("FAIL uf3_diff got %h want fe", d); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL uf3_uf got %b want 0", uf); end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [N-1:0] d = '0;
    logic uf = 1'b1;
    @(negedge clk);
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        if (dones == 0) begin d = diff; uf = underflow; end
        dones++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL ignore_diff got %h want 02", d); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL ignore_uf got %b want 0", uf); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int held_bad = 0;
    @(negedge clk);
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (diff !== 8'h02) begin n_fail++; $display("FAIL b2b_first_diff got %h want 02", diff); end
    @(negedge clk);
    a = 8'h09; b = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_immediate_busy got %b want 1", busy); end
    lat = 0;
    while (!done && lat < 20) begin
      if (diff !== 8'h02) held_bad++;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (held_bad != 0) begin n_fail++; $display("FAIL b2b_diff_hold got %0d changed cycles want 0", held_bad); end
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
    n_checks++; if (diff !== 8'hFF) begin n_fail++; $display("FAIL b2b_diff got %h want ff", diff); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL b2b_uf got %b want 1", underflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [N-1:0] d; logic uf, da; int lat, bc;
    @(negedge clk);
    a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    n_checks++; if (diff !== 8'h00) begin n_fail++; $display("FAIL midrst_diff got %h want 00", diff); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL midrst_uf got %b want 0", underflow); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    run_op(8'h7F, 8'h7F, 1'b0, d, uf, lat, bc, da);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL post_rst_latency got %0d want 8", lat); end
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL post_rst_diff got %h want 00", d); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL post_rst_uf got %b want 0", uf); end
  endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  task automatic test_signed_ovf();
    logic [N-1:0] d; logic uf, da; int lat, bc;
    run_op(8'h80, 8'h01, 1'b0, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'h7F) begin n_fail++; $display("FAIL ovf1_diff got %h want 7f", d); end
    n_checks++; if (signed_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf1_ovf got %b want 1", signed_ovf); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL ovf1_uf got %b want 0", uf); end
    run_op(8'h10, 8'h20, 1'b0, d, uf, lat, bc, da);
    n_checks++; if (d !== 8'hF0) begin n_fail++; $display("FAIL ovf2_diff got %h want f0", d); end
    n_checks++; if (signed_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf2_ovf got %b want 0", signed_ovf); end
    n_checks++; if (uf !== 1'b1) begin n_fail++; $display("FAIL ovf2_uf got %b want 1", uf); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    test_signed_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
